rotor_stepper: RTL and testbench

Parametrised Enigma rotor-stepping engine that generalises the fixed three-rotor stepper to `NUM_ROTORS` rotors over an `ALPHA`-letter alphabet. Each rotor has a runtime-programmable notch position. A runtime switch selects historical double-stepping or plain carry stepping. The block also supports mid-operation reload, a wrap indication and a step counter. It sits between the keypress debouncer and the substitution path, which reads `pos` each cycle.

---
 rtl/rotor_stepper_if.sv | 27 ++
 rtl/rotor_stepper.sv | 86 ++++++++
 tb/tb_rotor_stepper.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/rotor_stepper_if.sv
// Signal bundle between the keypress side, the rotor stepper and the substitution path.
// rotate is a level; a step is requested on its rising edge. There is no ready, and outputs are registered pulses/levels.
interface rotor_stepper_if #(
  parameter int NUM_ROTORS = 3,
  parameter int W          = 5,
  parameter int CNT_W      = 16
);
  logic                    rotate;
  logic                    load;
  logic                    double_step_en;
  logic [NUM_ROTORS*W-1:0] start_pos;
  logic [NUM_ROTORS*W-1:0] notch_pos;
  logic [NUM_ROTORS*W-1:0] pos;
  logic                    step_done;
  logic                    wrap_out;
  logic [CNT_W-1:0]        step_count;

  modport master (
    output rotate, load, double_step_en, start_pos, notch_pos,
    input  pos, step_done, wrap_out, step_count
  );

  modport slave (
    input  rotate, load, double_step_en, start_pos, notch_pos,
    output pos, step_done, wrap_out, step_count
  );
endinterface

// File: rtl/rotor_stepper.sv
// Enigma-style rotor stepping engine: N rotors over an ALPHA-letter alphabet,
// programmable notches, optional historical double-step, reload and step counter.
module rotor_stepper #(
  parameter int NUM_ROTORS = 3,
  parameter int ALPHA      = 26,
  parameter int W          = 5,
  parameter int CNT_W      = 16
) (
  input logic             clock,
  input logic             reset,
  rotor_stepper_if.slave  bus
);
  localparam logic [W-1:0] LAST = W'(ALPHA - 1);

  logic [W-1:0]          r_pos [NUM_ROTORS];
  logic                  r_prev_rotate;
  logic                  r_step_done;
  logic                  r_wrap_out;
  logic [CNT_W-1:0]      r_step_count;

  logic [W-1:0]          w_start [NUM_ROTORS];
  logic [W-1:0]          w_next  [NUM_ROTORS];
  logic [NUM_ROTORS-1:0] w_at_notch;
  logic [NUM_ROTORS-1:0] w_adv;
  logic                  w_step_req;
  logic                  w_wrap;

  assign w_step_req = bus.rotate && !r_prev_rotate;

  // Out-of-range start values clamp to 0; out-of-range notches can never match.
  always_comb begin
    for (int i = 0; i < NUM_ROTORS; i++) begin
      w_start[i]    = (32'(bus.start_pos[i*W +: W]) >= 32'(ALPHA)) ? '0 : bus.start_pos[i*W +: W];
      w_at_notch[i] = (32'(bus.notch_pos[i*W +: W]) < 32'(ALPHA)) &&
                      (r_pos[i] == bus.notch_pos[i*W +: W]);
    end
  end

  // All notch tests use pre-step positions, so a full cascade resolves in one edge.
  always_comb begin
    w_adv    = '0;
    w_adv[0] = 1'b1;
    for (int i = 1; i < NUM_ROTORS; i++) begin
      w_adv[i] = w_at_notch[i-1] ||
                 (bus.double_step_en && (i <= NUM_ROTORS - 2) && w_at_notch[i]);
    end
    for (int i = 0; i < NUM_ROTORS; i++) begin
      if (!w_adv[i])           w_next[i] = r_pos[i];
      else if (r_pos[i] == LAST) w_next[i] = '0;
      else                     w_next[i] = r_pos[i] + W'(1);
    end
  end

  assign w_wrap = w_adv[NUM_ROTORS-1] && (r_pos[NUM_ROTORS-1] == LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pos         <= w_start;
      r_prev_rotate <= 1'b1;
      r_step_done   <= 1'b0;
      r_wrap_out    <= 1'b0;
      r_step_count  <= '0;
    end else begin
      r_prev_rotate <= bus.rotate;
      r_step_done   <= 1'b0;
      r_wrap_out    <= 1'b0;
      if (bus.load) begin
        r_pos        <= w_start;
        r_step_count <= '0;
      end else if (w_step_req) begin
        r_pos        <= w_next;
        r_step_done  <= 1'b1;
        r_wrap_out   <= w_wrap;
        r_step_count <= r_step_count + CNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_ROTORS; g++) begin : g_pack
    assign bus.pos[g*W +: W] = r_pos[g];
  end

  assign bus.step_done  = r_step_done;
  assign bus.wrap_out   = r_wrap_out;
  assign bus.step_count = r_step_count;
endmodule

// File: tb/tb_rotor_stepper.sv
// Directed bench for rotor_stepper: vector table for the 3-rotor cases, hand-written
// sequences for key-held-through-reset and a 5-rotor/4-letter run against a small model.
module tb_rotor_stepper;
  logic clk;
  logic rst;

  rotor_stepper_if #(.NUM_ROTORS(3), .W(5), .CNT_W(16)) bus_a ();
  rotor_stepper_if #(.NUM_ROTORS(5), .W(3), .CNT_W(16)) bus_b ();

  rotor_stepper #(.NUM_ROTORS(3), .ALPHA(26), .W(5), .CNT_W(16)) dut_a (
    .clock (clk),
    .reset (rst),
    .bus   (bus_a)
  );

  rotor_stepper #(.NUM_ROTORS(5), .ALPHA(4), .W(3), .CNT_W(16)) dut_b (
    .clock (clk),
    .reset (rst),
    .bus   (bus_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        rst;
    logic        ld;
    logic        rot;
    logic        dse;
    logic [14:0] start;
    logic [14:0] notch;
    logic [14:0] exp_pos;
    logic        exp_done;
    logic        exp_wrap;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [14:0] p3(input int a, input int b, input int c);
    logic [4:0] x, y, z;
    x = a[4:0];
    y = b[4:0];
    z = c[4:0];
    return {x, y, z};
  endfunction

  function automatic vec_t mk(input logic r, input logic l, input logic ro, input logic d,
                              input logic [14:0] s, input logic [14:0] n, input logic [14:0] ep,
                              input logic ed, input logic ew, input int ec);
    vec_t v;
    v.rst = r; v.ld = l; v.rot = ro; v.dse = d;
    v.start = s; v.notch = n; v.exp_pos = ep;
    v.exp_done = ed; v.exp_wrap = ew; v.exp_cnt = ec[15:0];
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  m      [5];
  logic [4:0]  m_adv;
  logic [4:0]  m_notch;
  logic        m_wrap;
  logic [14:0] m_pos;
  logic        bad_range;

  initial begin
    logic [14:0] s1, n1, s3, n3, s5, s5b;
    rst = 1'b1;
    bus_a.rotate = 1'b0; bus_a.load = 1'b0; bus_a.double_step_en = 1'b0;
    bus_a.start_pos = '0; bus_a.notch_pos = '0;
    bus_b.rotate = 1'b0; bus_b.load = 1'b0; bus_b.double_step_en = 1'b1;
    bus_b.start_pos = '0; bus_b.notch_pos = {5{3'd3}};

    s1  = p3(0, 3, 20);  n1 = p3(31, 4, 21);
    s3  = p3(25, 25, 25); n3 = p3(25, 25, 25);
    s5  = p3(7, 8, 9);   s5b = p3(30, 8, 30);

    // double-step mode
    vecs.push_back(mk(1, 0, 0, 1, s1, n1, p3(0, 3, 20), 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, s1, n1, p3(0, 3, 20), 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, s1, n1, p3(0, 3, 21), 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, s1, n1, p3(0, 3, 21), 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, s1, n1, p3(0, 4, 22), 1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 1, s1, n1, p3(0, 4, 22), 0, 0, 2));
    vecs.push_back(mk(0, 0, 1, 1, s1, n1, p3(1, 5, 23), 1, 0, 3));
    vecs.push_back(mk(0, 0, 0, 1, s1, n1, p3(1, 5, 23), 0, 0, 3));
    // plain carry mode
    vecs.push_back(mk(1, 0, 0, 0, s1, n1, p3(0, 3, 20), 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, s1, n1, p3(0, 3, 20), 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, s1, n1, p3(0, 3, 21), 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, s1, n1, p3(0, 3, 21), 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, s1, n1, p3(0, 4, 22), 1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, s1, n1, p3(0, 4, 22), 0, 0, 2));
    vecs.push_back(mk(0, 0, 1, 0, s1, n1, p3(1, 4, 23), 1, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, s1, n1, p3(1, 4, 23), 0, 0, 3));
    // full cascade and wrap
    vecs.push_back(mk(1, 0, 0, 0, s3, n3, p3(25, 25, 25), 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, s3, n3, p3(25, 25, 25), 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, s3, n3, p3(0, 0, 0), 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, s3, n3, p3(0, 0, 0), 0, 0, 1));
    // load beats a coincident rising edge; out-of-range starts clamp to 0
    vecs.push_back(mk(0, 1, 1, 0, s5, n3, p3(7, 8, 9), 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, s5, n3, p3(7, 8, 9), 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, s5, n3, p3(7, 8, 9), 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, s5b, n3, p3(0, 8, 0), 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, s5b, n3, p3(0, 8, 1), 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, s5b, n3, p3(0, 8, 1), 0, 0, 1));

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      rst                  = vecs[k].rst;
      bus_a.load           = vecs[k].ld;
      bus_a.rotate         = vecs[k].rot;
      bus_a.double_step_en = vecs[k].dse;
      bus_a.start_pos      = vecs[k].start;
      bus_a.notch_pos      = vecs[k].notch;
      tick();
      check($sformatf("v%0d pos", k),  64'(bus_a.pos),        64'(vecs[k].exp_pos));
      check($sformatf("v%0d done", k), 64'(bus_a.step_done),  64'(vecs[k].exp_done));
      check($sformatf("v%0d wrap", k), 64'(bus_a.wrap_out),   64'(vecs[k].exp_wrap));
      check($sformatf("v%0d cnt", k),  64'(bus_a.step_count), 64'(vecs[k].exp_cnt));
    end

    // key held through reset deassertion must not step
    @(negedge clk);
    rst = 1'b1; bus_a.rotate = 1'b1; bus_a.load = 1'b0;
    bus_a.start_pos = p3(1, 2, 3); bus_a.notch_pos = p3(31, 31, 31);
    tick();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("hold%0d done", c), 64'(bus_a.step_done),  64'(0));
      check($sformatf("hold%0d cnt", c),  64'(bus_a.step_count), 64'(0));
    end
    @(negedge clk); bus_a.rotate = 1'b0;
    tick();
    @(negedge clk); bus_a.rotate = 1'b1;
    tick();
    check("hold press done", 64'(bus_a.step_done),  64'(1));
    check("hold press cnt",  64'(bus_a.step_count), 64'(1));
    check("hold press pos",  64'(bus_a.pos),        64'(p3(1, 2, 4)));
    @(negedge clk);
    tick();
    check("hold after done", 64'(bus_a.step_done),  64'(0));
    check("hold after cnt",  64'(bus_a.step_count), 64'(1));

    // 5 rotors over 4 letters, double-step on, against the model
    @(negedge clk); bus_b.load = 1'b1; bus_b.rotate = 1'b0;
    tick();
    @(negedge clk); bus_b.load = 1'b0;
    tick();
    check("b load pos", 64'(bus_b.pos),        64'(0));
    check("b load cnt", 64'(bus_b.step_count), 64'(0));
    for (int i = 0; i < 5; i++) m[i] = 3'd0;
    for (int p = 0; p < 300; p++) begin
      for (int i = 0; i < 5; i++) m_notch[i] = (m[i] == 3'd3);
      m_adv[0] = 1'b1;
      for (int i = 1; i < 5; i++) m_adv[i] = m_notch[i-1] || (i <= 3 && m_notch[i]);
      m_wrap = m_adv[4] && (m[4] == 3'd3);
      for (int i = 0; i < 5; i++)
        if (m_adv[i]) m[i] = (m[i] == 3'd3) ? 3'd0 : m[i] + 3'd1;
      m_pos = {m[4], m[3], m[2], m[1], m[0]};
      @(negedge clk); bus_b.rotate = 1'b1;
      tick();
      bad_range = 1'b0;
      for (int i = 0; i < 5; i++) if (bus_b.pos[i*3 +: 3] >= 3'd4) bad_range = 1'b1;
      check($sformatf("b p%0d pos", p),   64'(bus_b.pos),       64'(m_pos));
      check($sformatf("b p%0d wrap", p),  64'(bus_b.wrap_out),  64'(m_wrap));
      check($sformatf("b p%0d done", p),  64'(bus_b.step_done), 64'(1));
      check($sformatf("b p%0d range", p), 64'(bad_range),       64'(0));
      @(negedge clk); bus_b.rotate = 1'b0;
      tick();
    end
    check("b final cnt", 64'(bus_b.step_count), 64'(300));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
